// File: rtl/p2s_pkg.sv
// Shared definitions for the 3-wire serial link transmitter.
//   p2s_state_t  : transmitter FSM states
//   phase_cnt_w  : width of a down-counter that must hold values 0..n
//   bit_cnt_w    : width of the bit counter that must reach DATA_WIDTH
//   P2S_*        : default link geometry, also used by the receiver bench
package p2s_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOW   = 3'd1,
    HIGH  = 3'd2,
    TRAIL = 3'd3,
    GAP   = 3'd4
  } p2s_state_t;

  // Never returns 0 so a zero-length count still gets a legal 1-bit vector.
  function automatic int phase_cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic int bit_cnt_w(input int w);
    return (w < 1) ? 1 : $clog2(w + 1);
  endfunction

  localparam int P2S_DATA_WIDTH   = 15;
  localparam int P2S_CLK_DIV      = 4;
  localparam int P2S_GAP_CYCLES   = 2;
  // clk cycles serial_frame stays high for one word.
  localparam int P2S_FRAME_CYCLES = (2 * P2S_DATA_WIDTH + 1) * P2S_CLK_DIV;

endpackage

// File: rtl/p2s_phase_timer.sv
// Phase timer for the serial clock generator.
//   clk    : system clock
//   rst    : synchronous active-high reset
//   load   : restart a CLK_DIV-cycle phase (asserted on the phase-change edge)
//   expire : high during the last cycle of the current phase
// The counter is loaded with CLK_DIV-1 so that, counting the load edge, the
// phase lasts exactly CLK_DIV cycles; with CLK_DIV=1 every cycle expires.
module p2s_phase_timer
  import p2s_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expire
);

  localparam int PW = phase_cnt_w(CLK_DIV);
  localparam logic [PW-1:0] LOAD_VAL = PW'(CLK_DIV - 1);

  logic [PW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst)                r_cnt <= '0;
    else if (load)          r_cnt <= LOAD_VAL;
    else if (r_cnt != '0)   r_cnt <= r_cnt - PW'(1);
  end

  assign expire = (r_cnt == '0);

endmodule

// File: rtl/parallel2serial_transmitter.sv
// Transmit side of the 3-wire serial link (serial_clock/serial_data/serial_frame).
// Takes a DATA_WIDTH-bit word on a valid/ready handshake and shifts it out MSB
// first on a self-generated serial clock (CLK_DIV clk cycles per half period).
//   clk, rst      : system clock, synchronous active-high reset
//   ena           : enable; gates frame acceptance only
//   in_data       : word to send, sampled on the accept edge
//   in_valid      : in_data valid
//   in_ready      : high in IDLE with ena=1 and rst=0
//   busy          : high from the accept edge until IDLE is re-entered
//   tx_done       : one-cycle pulse on the first cycle after the frame
//   serial_clock  : idle low; receiver samples on its rising edge
//   serial_data   : changes only while serial_clock is low
//   serial_frame  : high for the whole frame including the trailing low phase
module parallel2serial_transmitter
  import p2s_pkg::*;
#(
  parameter int DATA_WIDTH = P2S_DATA_WIDTH,
  parameter int CLK_DIV    = P2S_CLK_DIV,
  parameter int GAP_CYCLES = P2S_GAP_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  busy,
  output logic                  tx_done,
  output logic                  serial_clock,
  output logic                  serial_data,
  output logic                  serial_frame
);

  localparam int BW = bit_cnt_w(DATA_WIDTH);
  localparam int GW = phase_cnt_w(GAP_CYCLES);
  localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  p2s_state_t            r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [BW-1:0]         r_bit_cnt;
  logic [GW-1:0]         r_gap_cnt;
  logic                  r_sclk;
  logic                  r_frame;
  logic                  r_busy;
  logic                  r_tx_done;

  logic                  w_accept;
  logic                  w_expire;
  logic                  w_load;
  logic [BW-1:0]         w_bit_nxt;

  assign in_ready  = (r_state == IDLE) & ena & ~rst;
  assign w_accept  = in_valid & in_ready;
  assign w_bit_nxt = r_bit_cnt + BW'(1);

  // Restart the phase timer on every edge that enters a clocked phase.
  assign w_load = w_accept |
                  (w_expire & ((r_state == LOW) | (r_state == HIGH) | (r_state == TRAIL)));

  p2s_phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (w_load),
    .expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_sclk    <= 1'b0;
      r_frame   <= 1'b0;
      r_busy    <= 1'b0;
      r_tx_done <= 1'b0;
    end else begin
      r_tx_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shift   <= in_data;
            r_bit_cnt <= '0;
            r_frame   <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= LOW;
          end
        end
        LOW: begin
          if (w_expire) begin
            r_sclk  <= 1'b1;
            r_state <= HIGH;
          end
        end
        HIGH: begin
          if (w_expire) begin
            r_sclk    <= 1'b0;
            r_bit_cnt <= w_bit_nxt;
            // Shifting on every exit leaves the register all-zero after the
            // last bit, which is what drives serial_data low in TRAIL.
            r_shift   <= {r_shift[DATA_WIDTH-2:0], 1'b0};
            r_state   <= (w_bit_nxt < BW'(DATA_WIDTH)) ? LOW : TRAIL;
          end
        end
        TRAIL: begin
          if (w_expire) begin
            r_frame   <= 1'b0;
            r_tx_done <= 1'b1;
            if (GAP_CYCLES == 0) begin
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_gap_cnt <= GAP_LOAD;
              r_state   <= GAP;
            end
          end
        end
        GAP: begin
          if (r_gap_cnt == '0) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt - GW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy         = r_busy;
  assign tx_done      = r_tx_done;
  assign serial_clock = r_sclk;
  assign serial_data  = r_shift[DATA_WIDTH-1];
  assign serial_frame = r_frame;

endmodule

// File: tb/tb_parallel2serial_transmitter.sv
module tb_parallel2serial_transmitter;

  localparam int W = 15;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] en, vld, rdy, bsy, txd, sck, sdt, sfr;
  logic [W-1:0] din [2];

  always #5 clk = ~clk;

  // Instance 0: default geometry. Instance 1: fastest clock, no gap.
  parallel2serial_transmitter #(.DATA_WIDTH(W), .CLK_DIV(4), .GAP_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .ena(en[0]), .in_data(din[0]), .in_valid(vld[0]),
    .in_ready(rdy[0]), .busy(bsy[0]), .tx_done(txd[0]),
    .serial_clock(sck[0]), .serial_data(sdt[0]), .serial_frame(sfr[0]));

  parallel2serial_transmitter #(.DATA_WIDTH(W), .CLK_DIV(1), .GAP_CYCLES(0)) dut1 (
    .clk(clk), .rst(rst), .ena(en[1]), .in_data(din[1]), .in_valid(vld[1]),
    .in_ready(rdy[1]), .busy(bsy[1]), .tx_done(txd[1]),
    .serial_clock(sck[1]), .serial_data(sdt[1]), .serial_frame(sfr[1]));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Receiver model: samples data on serial_clock rises inside the frame and
  // keeps a word only if the frame ends with tx_done.
  logic [W-1:0] rx_w [2];
  logic [W-1:0] last_word [2];
  int rx_bits [2], last_bits [2], frames_done [2], aborted [2], glitches [2];
  logic [1:0] p_sck, p_sfr, p_sdt;

  initial begin
    p_sck = '0; p_sfr = '0; p_sdt = '0;
    for (int k = 0; k < 2; k++) begin
      rx_w[k] = '0; last_word[k] = '0; rx_bits[k] = 0; last_bits[k] = 0;
      frames_done[k] = 0; aborted[k] = 0; glitches[k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (sfr[k] && sck[k] && !p_sck[k]) begin
          rx_w[k] = {rx_w[k][W-2:0], sdt[k]};
          rx_bits[k]++;
        end
        if (sck[k] && (sdt[k] != p_sdt[k])) glitches[k]++;
        if (p_sfr[k] && !sfr[k]) begin
          if (txd[k]) begin
            last_word[k] = rx_w[k];
            last_bits[k] = rx_bits[k];
            frames_done[k]++;
          end else begin
            aborted[k]++;
          end
          rx_bits[k] = 0;
          rx_w[k]    = '0;
        end
      end
      p_sck = sck; p_sfr = sfr; p_sdt = sdt;
    end
  end

  // Sends one word on instance k and measures, counting the cycle after the
  // accept edge as cycle 1: frame-high cycles, first tx_done cycle, number of
  // tx_done cycles, first cycle in_ready is back.
  task automatic send_timed(input int k, input logic [W-1:0] d,
                            output int flen, output int tdc, output int tdn, output int rdc);
    int t;
    flen = 0; tdc = 0; tdn = 0; rdc = 0; t = 0;
    @(negedge clk);
    while (!rdy[k] && t < 2000) begin @(negedge clk); t++; end
    chk("ready_before_send", int'(rdy[k]), 1);
    din[k] = d; vld[k] = 1'b1;
    @(posedge clk); #1;
    vld[k] = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (sfr[k]) flen++;
      if (txd[k]) begin tdn++; if (tdc == 0) tdc = c; end
      if (rdy[k]) begin rdc = c; break; end
    end
    chk("ready_return_seen", int'(rdc != 0), 1);
  endtask

  task automatic wait_frames(input int k, input int target, input string name);
    int t;
    t = 0;
    while (frames_done[k] < target && t < 1000) begin @(negedge clk); t++; end
    chk(name, int'(frames_done[k] >= target), 1);
  endtask

  typedef struct {
    logic [W-1:0] data;
    logic [W-1:0] exp_word;
    int exp_first;
    int exp_last;
    int exp_ones;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int flen, tdc, tdn, rdc, f0, a0, bad, t;
    logic [W-1:0] rw;

    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int flen, tdc, tdn, rdc, f0, a0, bad, t;
    logic [W-1:0] rw;

    tbl[0] = '{15'h4001, 15'h4001, 1, 1, 2};
    tbl[1] = '{15'h7FFF, 15'h7FFF, 1, 1, 15};
    tbl[2] = '{15'h0000, 15'h0000, 0, 0, 0};
    tbl[3] = '{15'h2AAA, 15'h2AAA, 0, 0, 7};
    tbl[4] = '{15'h5555, 15'h5555, 1, 1, 8};
    tbl[5] = '{15'h1234, 15'h1234, 0, 0, 5};

    rst = 1'b1; en = 2'b11; vld = 2'b00; din[0] = '0; din[1] = '0;

    // Reset
    @(posedge clk); @(negedge clk);
    chk("in_ready_low_in_reset", int'(rdy[0]), 0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_serial_clock", int'(sck[0]), 0);
    chk("rst_serial_data",  int'(sdt[0]), 0);
    chk("rst_serial_frame", int'(sfr[0]), 0);
    chk("rst_busy",         int'(bsy[0]), 0);
    chk("rst_tx_done",      int'(txd[0]), 0);
    chk("rst_in_ready",     int'(rdy[0]), 1);

    // Single frames, default geometry
    for (int i = 0; i < 6; i++) begin
      f0 = frames_done[0];
      send_timed(0, tbl[i].data, flen, tdc, tdn, rdc);
      chk("frame_count",   frames_done[0], f0 + 1);
      chk("word",          int'(last_word[0]), int'(tbl[i].exp_word));
      chk("sclk_rises",    last_bits[0], W);
      chk("first_bit",     int'(last_word[0][W-1]), tbl[i].exp_first);
      chk("last_bit",      int'(last_word[0][0]), tbl[i].exp_last);
      chk("ones",          $countones(last_word[0]), tbl[i].exp_ones);
      chk("frame_cycles",  flen, 124);
      chk("tx_done_cycle", tdc, 125);
      chk("tx_done_width", tdn, 1);
      chk("ready_cycle",   rdc, 127);
    end

    // Fastest clock, zero gap
    f0 = frames_done[1];
    send_timed(1, 15'h4001, flen, tdc, tdn, rdc);
    chk("d1_word",          int'(last_word[1]), 16'h4001);
    chk("d1_frame_cycles",  flen, 31);
    chk("d1_tx_done_cycle", tdc, 32);
    chk("d1_tx_done_width", tdn, 1);
    chk("d1_ready_cycle",   rdc, 32);

    // Back-to-back with in_valid held, data changed mid-frame
    @(negedge clk);
    f0 = frames_done[0];
    din[0] = 15'h7FFF; vld[0] = 1'b1;
    repeat (60) @(negedge clk);
    din[0] = 15'h0000;
    wait_frames(0, f0 + 1, "b2b_first_done");
    chk("b2b_first_word", int'(last_word[0]), 16'h7FFF);
    t = 0;
    while (bsy[0] && t < 50) begin @(negedge clk); t++; end
    t = 0;
    while (!bsy[0] && t < 50) begin @(negedge clk); t++; end
    chk("b2b_second_accepted", int'(bsy[0]), 1);
    vld[0] = 1'b0;
    wait_frames(0, f0 + 2, "b2b_second_done");
    chk("b2b_second_word", int'(last_word[0]), 0);

    // Reset at the 8th serial clock rise
    @(negedge clk);
    while (!rdy[0]) @(negedge clk);
    f0 = frames_done[0]; a0 = aborted[0];
    din[0] = 15'h2AAA; vld[0] = 1'b1;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    t = 0;
    while (rx_bits[0] < 8 && t < 200) begin @(negedge clk); t++; end
    chk("rst_mid_reached_rise8", rx_bits[0], 8);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_serial_clock", int'(sck[0]), 0);
    chk("abort_serial_data",  int'(sdt[0]), 0);
    chk("abort_serial_frame", int'(sfr[0]), 0);
    chk("abort_busy",         int'(bsy[0]), 0);
    chk("abort_tx_done",      int'(txd[0]), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_counted",     aborted[0], a0 + 1);
    chk("abort_no_done",     frames_done[0], f0);
    chk("abort_ready_again", int'(rdy[0]), 1);
    send_timed(0, 15'h2AAA, flen, tdc, tdn, rdc);
    chk("after_abort_word", int'(last_word[0]), 16'h2AAA);
    chk("after_abort_done", tdn, 1);

    // ena low in IDLE, then ena dropped mid-frame
    @(negedge clk);
    en[0] = 1'b0; din[0] = 15'h1234; vld[0] = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (rdy[0] || bsy[0] || sfr[0]) bad++;
    end
    chk("ena_low_no_frame", bad, 0);
    f0 = frames_done[0];
    en[0] = 1'b1;
    t = 0;
    while (!bsy[0] && t < 10) begin @(negedge clk); t++; end
    chk("ena_high_accepts", int'(bsy[0]), 1);
    vld[0] = 1'b0;
    repeat (40) @(negedge clk);
    en[0] = 1'b0;
    @(negedge clk);
    chk("ena_low_busy_not_ready", int'(rdy[0]), 0);
    wait_frames(0, f0 + 1, "ena_mid_frame_done");
    chk("ena_mid_frame_word", int'(last_word[0]), 16'h1234);
    t = 0;
    while (bsy[0] && t < 50) begin @(negedge clk); t++; end
    chk("ena_low_idle_ready", int'(rdy[0]), 0);
    en[0] = 1'b1;

    // Loopback of random words on both geometries
    for (int k = 0; k < 2; k++) begin
      bad = 0;
      for (int n = 0; n < 200; n++) begin
        rw = W'($urandom);
        f0 = frames_done[k];
        send_timed(k, rw, flen, tdc, tdn, rdc);
        if (frames_done[k] != f0 + 1 || last_word[k] != rw || last_bits[k] != W) begin
          bad++;
          $display("FAIL loopback%0d: word %0d sent 0x%0h received 0x%0h bits %0d", k, n, rw, last_word[k], last_bits[k]);
        end
      end
      chk("loopback_errors", bad, 0);
    end

    chk("d0_data_stable_while_sclk_high", glitches[0], 0);
    chk("d1_data_stable_while_sclk_high", glitches[1], 0);
    chk("d1_no_aborts", aborted[1], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
